// File: rtl/scan_pkg.sv
// Shared types and glyph constants for the serial digit scanner.
// Glyphs are {dp,g,f,e,d,c,b,a}, active-low.
package scan_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        SHIFT = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    localparam int DP_BIT = 7;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_A = 8'h88;
    localparam logic [7:0] SEG_B = 8'h83;
    localparam logic [7:0] SEG_C = 8'hC6;
    localparam logic [7:0] SEG_D = 8'hA1;
    localparam logic [7:0] SEG_E = 8'h86;
    localparam logic [7:0] SEG_F = 8'h8E;

    // Letters only render when hex_en is set; otherwise they are dark.
    function automatic logic [7:0] code_glyph(input logic [3:0] code, input logic hex_en);
        logic [7:0] g;
        case (code)
            4'h0:    g = SEG_0;
            4'h1:    g = SEG_1;
            4'h2:    g = SEG_2;
            4'h3:    g = SEG_3;
            4'h4:    g = SEG_4;
            4'h5:    g = SEG_5;
            4'h6:    g = SEG_6;
            4'h7:    g = SEG_7;
            4'h8:    g = SEG_8;
            4'h9:    g = SEG_9;
            4'hA:    g = hex_en ? SEG_A : SEG_BLANK;
            4'hB:    g = hex_en ? SEG_B : SEG_BLANK;
            4'hC:    g = hex_en ? SEG_C : SEG_BLANK;
            4'hD:    g = hex_en ? SEG_D : SEG_BLANK;
            4'hE:    g = hex_en ? SEG_E : SEG_BLANK;
            default: g = hex_en ? SEG_F : SEG_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/serial_digit_scanner_if.sv
// Display-side bundle: digit buffers in, serial LED board signals out.
// master = timekeeping/board side, slave = the scanner.
interface serial_digit_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic                    load;
    logic                    seg_sdo;
    logic                    seg_sclk;
    logic [NUM_DIGITS-1:0]   dig_sel;
    logic                    frame_done;

    modport master (
        output digits_in, dp_in, blank_in, blink_mask, load,
        input  seg_sdo, seg_sclk, dig_sel, frame_done
    );

    modport slave (
        input  digits_in, dp_in, blank_in, blink_mask, load,
        output seg_sdo, seg_sclk, dig_sel, frame_done
    );
endinterface

// File: rtl/serial_digit_scanner_seg_decoder.sv
// Combinational code/dp/blank to active-low glyph map, zero latency.
// SCAN_HEX_DECODE_EN enables letter glyphs for codes A-F; otherwise they are dark.
module seg_decoder
    import scan_pkg::*;
(
    input  logic [3:0] code,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] glyph
);
`ifdef SCAN_HEX_DECODE_EN
    localparam logic HEX_EN = 1'b1;
`else
    localparam logic HEX_EN = 1'b0;
`endif

    always_comb begin
        glyph = code_glyph(code, HEX_EN);
        if (dp)
            glyph[DP_BIT] = 1'b0;
        if (blank)
            glyph = SEG_BLANK;
    end
endmodule

// File: rtl/serial_digit_scanner.sv
// Multiplexed 7-seg scanner: per digit FETCH(1)+SHIFT(16)+SHOW(HOLD_TICKS) ticks, MSB-first serial glyph.
// No backpressure; load is always accepted. Letter glyphs follow SCAN_HEX_DECODE_EN.
module serial_digit_scanner
    import scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 2,
    parameter int HOLD_TICKS   = 64,
    parameter int BLINK_FRAMES = 32
) (
    input logic clk,
    input logic rst,
    serial_digit_scanner_if.slave bus
);
    localparam int TW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW     = $clog2(NUM_DIGITS);
    localparam int PH_MAX = (HOLD_TICKS > 16) ? HOLD_TICKS : 16;
    localparam int PW     = $clog2(PH_MAX);
    localparam int FW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef struct packed {
        logic [NUM_DIGITS-1:0][3:0] dig;
        logic [NUM_DIGITS-1:0]      dp;
        logic [NUM_DIGITS-1:0]      blank;
        logic [NUM_DIGITS-1:0]      blink;
    } disp_t;

    logic [TW-1:0]         tick_cnt;
    logic                  tick;
    disp_t                 pend;
    disp_t                 act;
    logic                  fresh;
    logic                  frame_end;
    scan_state_t           state;
    logic [IW-1:0]         idx;
    logic [PW-1:0]         ph_cnt;
    logic [7:0]            sr;
    logic [7:0]            glyph;
    logic [FW-1:0]         frame_cnt;
    logic                  blink_phase;
    logic                  sdo_q;
    logic                  sclk_q;
    logic [NUM_DIGITS-1:0] sel_q;
    logic                  done_q;

    assign bus.seg_sdo    = sdo_q;
    assign bus.seg_sclk   = sclk_q;
    assign bus.dig_sel    = sel_q;
    assign bus.frame_done = done_q;

    assign tick = (tick_cnt == TW'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    assign frame_end = tick && (state == SHOW) && (ph_cnt == PW'(HOLD_TICKS - 1))
                       && (idx == IW'(NUM_DIGITS - 1));

    // 'fresh' stands in for the FETCH-entry edge of the very first frame after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend  <= '{dig: '0, dp: '0, blank: '1, blink: '0};
            act   <= '{dig: '0, dp: '0, blank: '1, blink: '0};
            fresh <= 1'b1;
        end else begin
            fresh <= 1'b0;
            if (bus.load)
                pend <= {bus.digits_in, bus.dp_in, bus.blank_in, bus.blink_mask};
            if (fresh || frame_end)
                act <= pend;
        end
    end

    seg_decoder u_dec (
        .code  (act.dig[idx]),
        .dp    (act.dp[idx]),
        .blank (act.blank[idx] | (act.blink[idx] & blink_phase)),
        .glyph (glyph)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            idx         <= '0;
            ph_cnt      <= '0;
            sr          <= SEG_BLANK;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            sdo_q       <= 1'b1;
            sclk_q      <= 1'b0;
            sel_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (tick) begin
                unique case (state)
                    FETCH: begin
                        sr     <= glyph;
                        sdo_q  <= glyph[7];
                        ph_cnt <= '0;
                        state  <= SHIFT;
                    end
                    SHIFT: begin
                        // Even phases raise sclk; odd phases drop it and present the next bit.
                        sclk_q <= ~ph_cnt[0];
                        if (ph_cnt[0]) begin
                            sdo_q <= (ph_cnt == PW'(15)) ? 1'b1 : sr[6];
                            sr    <= {sr[6:0], 1'b1};
                        end
                        if (ph_cnt == PW'(15)) begin
                            ph_cnt <= '0;
                            sel_q  <= NUM_DIGITS'(1) << idx;
                            state  <= SHOW;
                        end else begin
                            ph_cnt <= ph_cnt + 1'b1;
                        end
                    end
                    SHOW: begin
                        if (ph_cnt == PW'(HOLD_TICKS - 1)) begin
                            ph_cnt <= '0;
                            sel_q  <= '0;
                            state  <= FETCH;
                            if (idx == IW'(NUM_DIGITS - 1)) begin
                                idx    <= '0;
                                done_q <= 1'b1;
                                if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                                    frame_cnt   <= '0;
                                    blink_phase <= ~blink_phase;
                                end else begin
                                    frame_cnt <= frame_cnt + 1'b1;
                                end
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else begin
                            ph_cnt <= ph_cnt + 1'b1;
                        end
                    end
                    default: state <= FETCH;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_serial_digit_scanner.sv
// Frame-table bench for serial_digit_scanner: captures each shifted byte and checks it against a queue.
module tb_serial_digit_scanner;
    localparam int ND = 4;
    localparam int CD = 2;
    localparam int HT = 4;
    localparam int BF = 2;
    localparam int FRAME_CLKS = ND * (17 + HT) * CD;
`ifdef SCAN_HEX_DECODE_EN
    localparam bit HEX = 1'b1;
`else
    localparam bit HEX = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    serial_digit_scanner_if #(.NUM_DIGITS(ND)) bus ();

    serial_digit_scanner #(
        .NUM_DIGITS  (ND),
        .CLK_DIV     (CD),
        .HOLD_TICKS  (HT),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] byt;
    } slot_t;

    typedef struct packed {
        logic [15:0]     dig;
        logic [3:0]      dp;
        logic [3:0]      blank;
        logic [3:0]      blink;
        logic [3:0][7:0] exp;
    } row_t;

    slot_t exp_q[$];
    row_t  rows[10];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic push_frame(input logic [3:0][7:0] e, input int n);
        slot_t s;
        for (int i = 0; i < n; i++) begin
            s.sel = 4'b0001 << i;
            s.byt = e[i];
            exp_q.push_back(s);
        end
    endtask

    task automatic wait_frame();
        bit seen = 1'b0;
        for (int i = 0; i < 2 * FRAME_CLKS && !seen; i++) begin
            @(negedge clk);
            if (bus.frame_done)
                seen = 1'b1;
        end
        if (!seen)
            fail_now("frame_done wait");
    endtask

    task automatic wait_sel(input logic [3:0] v);
        bit seen = 1'b0;
        for (int i = 0; i < 2 * FRAME_CLKS && !seen; i++) begin
            @(negedge clk);
            if (bus.dig_sel == v)
                seen = 1'b1;
        end
        if (!seen)
            fail_now("dig_sel wait");
    endtask

    task automatic apply_row(input row_t r);
        bus.digits_in  = r.dig;
        bus.dp_in      = r.dp;
        bus.blank_in   = r.blank;
        bus.blink_mask = r.blink;
        bus.load       = 1'b1;
    endtask

    // Serial capture: sample sdo on each sclk rise, close the byte when a select appears.
    logic       prev_sclk, prev_fd, sel_bad;
    logic [3:0] prev_sel;
    logic [7:0] cur;
    int         nbits, cyc;
    slot_t      got, want;

    always @(negedge clk) begin
        if (rst) begin
            prev_sclk = 1'b0; prev_fd = 1'b0; sel_bad = 1'b0;
            prev_sel = '0; cur = '0; nbits = 0; cyc = 0;
        end else begin
            cyc++;
            if (bus.seg_sclk && !prev_sclk) begin
                cur = {cur[6:0], bus.seg_sdo};
                nbits++;
                if (bus.dig_sel != 4'b0)
                    sel_bad = 1'b1;
            end
            if (bus.dig_sel != 4'b0 && prev_sel == 4'b0) begin
                got.sel = bus.dig_sel;
                got.byt = cur;
                if (exp_q.size() == 0) begin
                    fail_now("unexpected slot");
                end else begin
                    want = exp_q.pop_front();
                    check("slot dig_sel", 32'(got.sel), 32'(want.sel));
                    check("slot byte", 32'(got.byt), 32'(want.byt));
                    check("slot bit count", nbits, 8);
                    check("dig_sel during shift", 32'(sel_bad), 0);
                end
                nbits = 0;
                sel_bad = 1'b0;
            end
            if (bus.frame_done) begin
                check("frame period", cyc, FRAME_CLKS);
                check("frame_done width", 32'(prev_fd), 0);
                cyc = 0;
            end
            prev_sclk = bus.seg_sclk;
            prev_sel  = bus.dig_sel;
            prev_fd   = bus.frame_done;
        end
    end

    initial begin
        bus.digits_in  = '0;
        bus.dp_in      = '0;
        bus.blank_in   = '0;
        bus.blink_mask = '0;
        bus.load       = 1'b0;

        // Frame-indexed table: inputs are loaded during the previous frame; blink phase is 1 in frames 2,3,6,7.
        rows[0] = '{dig: 16'h0000, dp: 4'b0000, blank: 4'b1111, blink: 4'b0000, exp: {8'hFF, 8'hFF, 8'hFF, 8'hFF}};
        rows[1] = '{dig: 16'h1234, dp: 4'b0000, blank: 4'b0000, blink: 4'b0000, exp: {8'hF9, 8'hA4, 8'hB0, 8'h99}};
        rows[2] = '{dig: 16'h1834, dp: 4'b0100, blank: 4'b0000, blink: 4'b0000, exp: {8'hF9, 8'h00, 8'hB0, 8'h99}};
        rows[3] = '{dig: 16'h5E70, dp: 4'b0000, blank: 4'b0000, blink: 4'b0001,
                    exp: {8'h92, (HEX ? 8'h86 : 8'hFF), 8'hF8, 8'hFF}};
        rows[4] = '{dig: 16'h1234, dp: 4'b0000, blank: 4'b0000, blink: 4'b0001, exp: {8'hF9, 8'hA4, 8'hB0, 8'h99}};
        rows[5] = rows[4];
        rows[6] = '{dig: 16'h1234, dp: 4'b0000, blank: 4'b0000, blink: 4'b0001, exp: {8'hF9, 8'hA4, 8'hB0, 8'hFF}};
        rows[7] = rows[6];
        rows[8] = '{dig: 16'h1234, dp: 4'b0001, blank: 4'b1000, blink: 4'b0001, exp: {8'hFF, 8'hA4, 8'hB0, 8'h19}};
        rows[9] = '{dig: 16'hDCBA, dp: 4'b0010, blank: 4'b0000, blink: 4'b0000,
                    exp: {(HEX ? 8'hA1 : 8'hFF), (HEX ? 8'hC6 : 8'hFF), (HEX ? 8'h03 : 8'h7F), (HEX ? 8'h88 : 8'hFF)}};

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset seg_sdo", 32'(bus.seg_sdo), 1);
        check("reset seg_sclk", 32'(bus.seg_sclk), 0);
        check("reset dig_sel", 32'(bus.dig_sel), 0);
        check("reset frame_done", 32'(bus.frame_done), 0);

        // Load in the first cycle after reset misses frame 0's copy.
        push_frame(rows[0].exp, ND);
        apply_row(rows[1]);
        #2 rst = 1'b0;
        @(posedge clk);
        #1 bus.load = 1'b0;
        wait_frame();

        for (int f = 1; f < 10; f++) begin
            push_frame(rows[f].exp, ND);
            if (f < 9) begin
                repeat (80) @(posedge clk);
                #1 apply_row(rows[f + 1]);
                @(posedge clk);
                #1 bus.load = 1'b0;
            end
            wait_frame();
        end

        // Reset while digit 2 is mid-shift with sclk high.
        push_frame(rows[9].exp, 2);
        wait_sel(4'b0010);
        wait_sel(4'b0000);
        begin
            bit hi = 1'b0;
            for (int i = 0; i < 40 && !hi; i++) begin
                @(negedge clk);
                if (bus.seg_sclk)
                    hi = 1'b1;
            end
            if (!hi)
                fail_now("sclk high wait");
        end
        #2 rst = 1'b1;
        #1;
        check("async rst dig_sel", 32'(bus.dig_sel), 0);
        check("async rst seg_sclk", 32'(bus.seg_sclk), 0);
        check("async rst seg_sdo", 32'(bus.seg_sdo), 1);
        check("slots before rst", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        exp_q.delete();
        push_frame({8'hFF, 8'hFF, 8'hFF, 8'hFF}, ND);
        #2 rst = 1'b0;
        wait_frame();
        check("slots after dark frame", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
